// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit width, active-low glyph table and the
// key debouncer state type used by the HEX counter slice.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g in bits 0..6, dp (bit 7) held off.
  localparam logic [7:0] SEG_DIGIT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    KEY_UNARMED,
    KEY_RELEASED,
    KEY_PRESSED
  } keyState_e;

  function automatic logic [7:0] seg7_encode(input logic [DIGIT_W-1:0] digit);
    return SEG_DIGIT[digit];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press.
module key_debounce
  import seg7_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic keyN,
  output logic pressPulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncMeta;
  logic             syncKey;
  keyState_e        state;
  keyState_e        nextState;
  logic [CNT_W-1:0] stableCnt;
  logic [CNT_W-1:0] nextCnt;
  logic             nextPulse;
  logic             targetLevel;

  // Synchroniser comes out of reset reading "pressed" so a key that is still
  // held must be seen released before the debouncer arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta <= 1'b0;
      syncKey  <= 1'b0;
    end else begin
      syncMeta <= keyN;
      syncKey  <= syncMeta;
    end
  end

  // NOTE: every output of a combinational block gets a default before any branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    nextState   = state;
    nextCnt     = '0;
    nextPulse   = 1'b0;
    targetLevel = (state == KEY_RELEASED) ? 1'b0 : 1'b1;
    if (syncKey == targetLevel) begin
      if (stableCnt == CNT_LAST) begin
        case (state)
          KEY_UNARMED:  nextState = KEY_RELEASED;
          KEY_PRESSED:  nextState = KEY_RELEASED;
          KEY_RELEASED: begin
            nextState = KEY_PRESSED;
            nextPulse = 1'b1;
          end
          default:      nextState = KEY_UNARMED;
        endcase
      end else begin
        nextCnt = stableCnt + 1'b1;
      end
    end
  end

  // NOTE: clocked state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= KEY_UNARMED;
      stableCnt  <= '0;
      pressPulse <= 1'b0;
    end else begin
      state      <= nextState;
      stableCnt  <= nextCnt;
      pressPulse <= nextPulse;
    end
  end

endmodule

// File: rtl/seg7_multi_counter.sv
// N-digit hex/decimal up/down counter stepped by a debounced key, with parallel
// load, wrap pulse and registered active-low seven-segment outputs.
module seg7_multi_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_LZ        = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_n,
  input  logic                          up,
  input  logic                          dec_mode,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          wrap,
  output logic [8*NUM_DIGITS-1:0]       hex
);

  localparam int CW = DIGIT_W * NUM_DIGITS;

  logic          stepPulse;
  logic [CW-1:0] countNext;
  logic          wrapNext;
  logic [8*NUM_DIGITS-1:0] hexNext;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk       (clk),
    .reset     (reset),
    .keyN      (step_n),
    .pressPulse(stepPulse)
  );

  // NOTE: the ripple below relies on blocking assignments inside always_comb; each digit must see the carry left by the one before it.
  always_comb begin
    logic [DIGIT_W-1:0] digitMax;
    logic [DIGIT_W-1:0] d;
    logic               ripple;
    digitMax  = dec_mode ? DIGIT_W'(9) : DIGIT_W'(15);
    d         = '0;
    ripple    = 1'b1;
    countNext = count;
    wrapNext  = 1'b0;
    if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d = load_value[i*DIGIT_W +: DIGIT_W];
        countNext[i*DIGIT_W +: DIGIT_W] = (dec_mode && d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
      end
    end else if (stepPulse) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d = count[i*DIGIT_W +: DIGIT_W];
        if (ripple) begin
          if (up) begin
            // Stale decimal digits above 9 roll to 0 and carry like 9 does.
            if (d >= digitMax) begin
              countNext[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
              countNext[i*DIGIT_W +: DIGIT_W] = d + 1'b1;
              ripple = 1'b0;
            end
          end else begin
            if (d == '0) begin
              countNext[i*DIGIT_W +: DIGIT_W] = digitMax;
            end else if (d > digitMax) begin
              countNext[i*DIGIT_W +: DIGIT_W] = digitMax;
              ripple = 1'b0;
            end else begin
              countNext[i*DIGIT_W +: DIGIT_W] = d - 1'b1;
              ripple = 1'b0;
            end
          end
        end
      end
      wrapNext = ripple;
    end
  end

  // Leading-zero blanking scans from the top digit down; digit 0 always shows.
  always_comb begin
    logic               zeroAbove;
    logic [DIGIT_W-1:0] dispDigit;
    zeroAbove = 1'b1;
    dispDigit = '0;
    hexNext   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dispDigit = count[i*DIGIT_W +: DIGIT_W];
      zeroAbove = zeroAbove && (dispDigit == '0);
      if (BLANK_LZ != 0 && i > 0 && zeroAbove) begin
        hexNext[8*i +: 8] = SEG_BLANK;
      end else begin
        hexNext[8*i +: 8] = seg7_encode(dispDigit);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex[8*i +: 8] <= (BLANK_LZ != 0 && i > 0) ? SEG_BLANK : seg7_encode('0);
      end
    end else begin
      count <= countNext;
      wrap  <= wrapNext;
      hex   <= hexNext;
    end
  end

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Self-checking bench for seg7_multi_counter (2 digits, 4-cycle debounce, blanking on):
// directed cases pinned with literals plus a randomized phase against a behavioural model.
module tb_seg7_multi_counter;

  localparam int ND  = 2;
  localparam int DEB = 4;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          step_n;
  logic          up;
  logic          dec_mode;
  logic          load;
  logic [4*ND-1:0] load_value;
  logic [4*ND-1:0] count;
  logic          wrap;
  logic [8*ND-1:0] hex;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model state: key seen two edges late, debounced level, run length.
  int   mRaw1, mRaw2, mLevel, mRun;
  bit   mPending;
  int   mDig [ND];
  bit   mWrap;
  logic [8*ND-1:0] mHex;

  seg7_multi_counter #(
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(DEB),
    .BLANK_LZ       (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_n    (step_n),
    .up        (up),
    .dec_mode  (dec_mode),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .wrap      (wrap),
    .hex       (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [8*ND-1:0] hexOf(input int d0, input int d1);
    logic [7:0] top;
    top = (d1 == 0) ? 8'hFF : SEG_TAB[d1];
    return {top, SEG_TAB[d0]};
  endfunction

  function automatic logic [4*ND-1:0] modelCount();
    return {4'(mDig[1]), 4'(mDig[0])};
  endfunction

  task automatic modelEdge();
    int maxd, k, syncd;
    bit newPending;
    if (reset) begin
      mRaw1 = 0; mRaw2 = 0; mLevel = 0; mRun = 0; mPending = 0;
      mDig[0] = 0; mDig[1] = 0; mWrap = 0;
      mHex = hexOf(0, 0);
      return;
    end
    mHex  = hexOf(mDig[0], mDig[1]);
    maxd  = dec_mode ? 9 : 15;
    mWrap = 0;
    if (load) begin
      for (int i = 0; i < ND; i++) begin
        k = int'(load_value[4*i +: 4]);
        mDig[i] = (dec_mode && k > 9) ? 9 : k;
      end
    end else if (mPending) begin
      k = 0;
      if (up) begin
        while (k < ND && mDig[k] >= maxd) begin mDig[k] = 0; k++; end
        if (k == ND) mWrap = 1; else mDig[k] = mDig[k] + 1;
      end else begin
        while (k < ND && mDig[k] == 0) begin mDig[k] = maxd; k++; end
        if (k == ND) mWrap = 1;
        else mDig[k] = (mDig[k] - 1 > maxd) ? maxd : mDig[k] - 1;
      end
    end
    syncd = mRaw2;
    mRaw2 = mRaw1;
    mRaw1 = int'(step_n);
    newPending = 0;
    if (syncd != mLevel) begin
      mRun++;
      if (mRun == DEB) begin
        mLevel = syncd;
        mRun   = 0;
        if (syncd == 0) newPending = 1;
      end
    end else begin
      mRun = 0;
    end
    mPending = newPending;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    modelEdge();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      check("model_count", 32'(count), 32'(modelCount()));
      check("model_wrap",  32'(wrap),  32'(mWrap));
      check("model_hex",   32'(hex),   32'(mHex));
    end
  end

  task automatic loadValue(input logic [4*ND-1:0] v);
    load_value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic pressKey(output int wraps);
    wraps = 0;
    step_n = 1'b0;
    repeat (10) begin @(negedge clk); if (wrap) wraps++; end
    step_n = 1'b1;
    repeat (10) begin @(negedge clk); if (wrap) wraps++; end
  endtask

  initial begin
    int w;
    reset = 1'b1; step_n = 1'b1; up = 1'b1; dec_mode = 1'b0;
    load = 1'b0; load_value = '0;
    repeat (3) @(negedge clk);
    check("reset_count", 32'(count), 32'h00);
    check("reset_wrap",  32'(wrap),  32'h0);
    check("reset_hex",   32'(hex),   32'hFFC0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Bouncy press: 1-cycle glitches then a solid hold.
    step_n = 1'b0; @(negedge clk);
    step_n = 1'b1; @(negedge clk);
    step_n = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_count", 32'(count), 32'h01);
    check("bounce_hex",   32'(hex),   32'hFFF9);
    repeat (50) @(negedge clk);
    check("hold_no_repeat", 32'(count), 32'h01);
    step_n = 1'b1;
    repeat (10) @(negedge clk);
    check("release_no_step", 32'(count), 32'h01);

    dec_mode = 1'b1; up = 1'b1;
    loadValue(8'h99);
    pressKey(w);
    check("dec_wrap_count", 32'(count), 32'h00);
    check("dec_wrap_pulse", 32'(w), 32'd1);
    check("dec_wrap_hex",   32'(hex), 32'hFFC0);

    dec_mode = 1'b0;
    loadValue(8'hFF);
    pressKey(w);
    check("hex_wrap_count", 32'(count), 32'h00);
    check("hex_wrap_pulse", 32'(w), 32'd1);

    loadValue(8'h00);
    up = 1'b0;
    pressKey(w);
    check("down_wrap_count", 32'(count), 32'hFF);
    check("down_wrap_pulse", 32'(w), 32'd1);
    check("down_wrap_hex",   32'(hex), 32'h8E8E);
    pressKey(w);
    check("down_again", 32'(count), 32'hFE);
    check("down_again_wrap", 32'(w), 32'd0);

    dec_mode = 1'b1;
    loadValue(8'hA7);
    check("load_clamp", 32'(count), 32'h97);
    @(negedge clk);
    check("load_clamp_hex", 32'(hex), 32'h90F8);
    load_value = 8'h42; load = 1'b1;
    pressKey(w);
    load = 1'b0;
    check("load_beats_step", 32'(count), 32'h42);
    check("load_no_wrap", 32'(w), 32'd0);

    // Stale hex digit after switching to decimal.
    dec_mode = 1'b0; loadValue(8'h3C);
    dec_mode = 1'b1; up = 1'b1;
    pressKey(w);
    check("stale_inc", 32'(count), 32'h40);
    dec_mode = 1'b0; loadValue(8'h3C);
    dec_mode = 1'b1; up = 1'b0;
    pressKey(w);
    check("stale_dec", 32'(count), 32'h39);

    // Reset in the middle of a held press.
    dec_mode = 1'b0; up = 1'b1;
    loadValue(8'h05);
    step_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_count", 32'(count), 32'h00);
    check("midreset_wrap",  32'(wrap),  32'h0);
    check("midreset_hex",   32'(hex),   32'hFFC0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("held_after_reset", 32'(count), 32'h00);
    step_n = 1'b1;
    repeat (10) @(negedge clk);
    pressKey(w);
    check("repress_after_reset", 32'(count), 32'h01);

    // Randomized phase, checked each cycle by the model compare.
    for (int it = 0; it < 40; it++) begin
      dec_mode = 1'($urandom_range(0, 1));
      up       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        loadValue(8'($urandom));
      end else begin
        repeat ($urandom_range(0, 4)) begin
          step_n = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        step_n = 1'b0;
        repeat ($urandom_range(5, 12)) @(negedge clk);
        repeat ($urandom_range(0, 4)) begin
          step_n = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        step_n = 1'b1;
        repeat ($urandom_range(6, 10)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
